// File: rtl/tx_pkg.sv
// Shared types and constants for the TX sequencer.
package tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } tx_state_t;

    localparam int TX_WORD_WIDTH = 32;

    // Width of the bit-period counter. It never drops below 1, so that a
    // divide-by-one timer still has a real register to compare against.
    function automatic int clk_cnt_width(input int clks_per_bit);
        return (clks_per_bit <= 1) ? 1 : $clog2(clks_per_bit);
    endfunction

endpackage

// File: rtl/tx_ctrl_if.sv
// Upstream word handshake plus the strobes and word sent to the TX shift register.
interface tx_ctrl_if import tx_pkg::*; #(
    parameter int DATA_WIDTH = TX_WORD_WIDTH
) ();

    logic                  data_valid;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_ready;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  load_enable;
    logic                  tx_enable;
    logic                  tx_busy;
    logic                  tx_done;

    // Environment side: offers words and watches the shift-register controls.
    modport master (
        output data_valid, data_in,
        input  data_ready, tx_data, load_enable, tx_enable, tx_busy, tx_done
    );

    // Controller side.
    modport slave (
        input  data_valid, data_in,
        output data_ready, tx_data, load_enable, tx_enable, tx_busy, tx_done
    );

endinterface

// File: rtl/tx_bit_timer.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 while enabled and strobes on
// the terminal count, so each serial bit is held for exactly CLKS_PER_BIT clocks.
module tx_bit_timer import tx_pkg::*; #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic strobe_o
);

    localparam int              CNT_W    = clk_cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] clk_cnt_q;
    logic [CNT_W-1:0] clk_cnt_d;

    // Next count: clear wins, otherwise advance and wrap at the terminal value.
    always_comb begin
        clk_cnt_d = clk_cnt_q;
        if (clear_i) begin
            clk_cnt_d = '0;
        end else if (enable_i) begin
            clk_cnt_d = (clk_cnt_q == CNT_LAST) ? '0 : clk_cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            clk_cnt_q <= '0;
        end else begin
            clk_cnt_q <= clk_cnt_d;
        end
    end

    // Strobe is decoded from the registered count only.
    assign strobe_o = enable_i && (clk_cnt_q == CNT_LAST);

endmodule

// File: rtl/tx_ctrl.sv
// Transmit sequencer: accepts a word in IDLE, strobes a parallel load, then
// issues DATA_WIDTH shift strobes one bit period apart and pulses tx_done.
// Every output is either a register or a decode of registered state, so no
// combinational path exists from data_valid to any output.
module tx_ctrl import tx_pkg::*; #(
    parameter int DATA_WIDTH   = TX_WORD_WIDTH,
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    tx_ctrl_if.slave   bus
);

    localparam int               BIT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    tx_state_t             state_q, state_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  timer_clear;
    logic                  timer_en;
    logic                  bit_strobe;

    // The divider only runs in SHIFT and sits at zero everywhere else, so the
    // first bit period starts cleanly on the cycle after LOAD.
    assign timer_clear = (state_q != SHIFT);
    assign timer_en    = (state_q == SHIFT);

    tx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .n_rst    (n_rst),
        .clear_i  (timer_clear),
        .enable_i (timer_en),
        .strobe_o (bit_strobe)
    );

    // Next state, bit counter and word capture.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        tx_data_d = tx_data_q;
        case (state_q)
            IDLE: begin
                // data_ready is implied by IDLE, so valid alone completes the handshake.
                if (bus.data_valid) begin
                    tx_data_d = bus.data_in;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                bit_cnt_d = '0;
                state_d   = SHIFT;
            end
            SHIFT: begin
                if (bit_strobe) begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and word registers; reset discards any word in flight.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            tx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            tx_data_q <= tx_data_d;
        end
    end

    // Output decode from registered state; load and shift come from disjoint states.
    always_comb begin
        bus.data_ready  = (state_q == IDLE);
        bus.load_enable = (state_q == LOAD);
        bus.tx_enable   = bit_strobe;
        bus.tx_busy     = (state_q == LOAD) || (state_q == SHIFT);
        bus.tx_done     = (state_q == DONE);
        bus.tx_data     = tx_data_q;
    end

endmodule

// File: tb/tb_tx_ctrl.sv
// Directed bench for tx_ctrl: one DUT at the default bit period, one at
// CLKS_PER_BIT=1, sharing stimulus through a select line.
module tb_tx_ctrl;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        sel = 1'b0;
    logic        tb_valid = 1'b0;
    logic [31:0] tb_data = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tx_ctrl_if #(.DATA_WIDTH(32)) if_a ();
    tx_ctrl_if #(.DATA_WIDTH(32)) if_b ();

    assign if_a.data_valid = tb_valid & ~sel;
    assign if_a.data_in    = tb_data;
    assign if_b.data_valid = tb_valid & sel;
    assign if_b.data_in    = tb_data;

    tx_ctrl #(.DATA_WIDTH(32), .CLKS_PER_BIT(8)) dut_a (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (if_a.slave)
    );

    tx_ctrl #(.DATA_WIDTH(32), .CLKS_PER_BIT(1)) dut_b (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (if_b.slave)
    );

    // Observed signals of whichever DUT is selected.
    logic        m_ready, m_load, m_en, m_busy, m_done;
    logic [31:0] m_data;
    assign m_ready = sel ? if_b.data_ready  : if_a.data_ready;
    assign m_load  = sel ? if_b.load_enable : if_a.load_enable;
    assign m_en    = sel ? if_b.tx_enable   : if_a.tx_enable;
    assign m_busy  = sel ? if_b.tx_busy     : if_a.tx_busy;
    assign m_done  = sel ? if_b.tx_done     : if_a.tx_done;
    assign m_data  = sel ? if_b.tx_data     : if_a.tx_data;

    // Frame statistics filled in by capture().
    int          st_load, st_nload, st_nen, st_first, st_last, st_gap_bad;
    int          st_done, st_overlap, st_ready_busy, st_data_chg;
    logic [31:0] st_stream, st_word;

    // Offer a word and wait for the accept edge; returns at cycle 1 (+1ns).
    task automatic send_word(input logic [31:0] w, input bit hold);
        int n;
        n = 0;
        tb_data  = w;
        tb_valid = 1'b1;
        while (!m_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (m_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready: data_ready=%b required 1", m_ready);
        end
        @(posedge clk); #1;
        if (!hold) tb_valid = 1'b0;
    endtask

    // Follow one frame from cycle 1, modelling the shift register's serial output.
    task automatic capture(input int max_cyc, input int cpb);
        int          prev_en;
        logic [31:0] sr;
        prev_en = -1; sr = '0;
        st_load = -1; st_nload = 0; st_nen = 0; st_first = -1; st_last = -1;
        st_gap_bad = 0; st_done = -1; st_overlap = 0; st_ready_busy = 0;
        st_data_chg = 0; st_stream = '0; st_word = '0;
        for (int c = 1; c <= max_cyc; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
            end
            if (m_load && m_en) st_overlap++;
            if (m_ready) st_ready_busy++;
            if (st_load > 0 && m_data !== st_word) st_data_chg++;
            if (m_load) begin
                st_nload++;
                if (st_load < 0) begin
                    st_load = c;
                    st_word = m_data;
                    sr      = m_data;
                end
            end
            if (m_en) begin
                st_nen++;
                if (prev_en < 0) st_first = c;
                else if (c - prev_en != cpb) st_gap_bad++;
                prev_en   = c;
                st_last   = c;
                st_stream = {st_stream[30:0], sr[31]};
                sr        = {sr[30:0], 1'b0};
            end
            if (m_done) begin
                st_done = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int n;
        n_rst = 1'b0; sel = 1'b0; tb_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({m_ready, m_busy, m_load, m_en, m_done} !== 5'b10000 || m_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: ready/busy/load/en/done=%b data=%h required 10000 data=00000000",
                     {m_ready, m_busy, m_load, m_en, m_done}, m_data);
        end
        n_rst = 1'b1;
        @(posedge clk); #1;
        send_word(32'hC0DE_F00D, 1'b0);
        n = 0;
        while (!m_en && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (m_en !== 1'b1) begin
            errors++;
            $display("FAIL reset_reach_shift: tx_enable=%b required 1", m_en);
        end
        n_rst = 1'b0;
        #1;
        checks++;
        if (m_en !== 1'b0 || m_busy !== 1'b0 || m_ready !== 1'b1 || m_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_shift: en=%b busy=%b ready=%b data=%h required 0 0 1 00000000",
                     m_en, m_busy, m_ready, m_data);
        end
        @(posedge clk); #1;
        n_rst = 1'b1;
        @(posedge clk); #1;
        $display("test_reset: reset checked idle and mid-shift");
    endtask

    task automatic test_single();
        sel = 1'b0;
        send_word(32'hA5A5_0F0F, 1'b0);
        capture(300, 8);
        checks++;
        if (st_load != 1 || st_nload != 1) begin
            errors++;
            $display("FAIL single_load: cycle=%0d count=%0d required cycle 1 count 1", st_load, st_nload);
        end
        checks++;
        if (st_first != 9 || st_last != 257 || st_nen != 32 || st_gap_bad != 0) begin
            errors++;
            $display("FAIL single_shift: first=%0d last=%0d n=%0d badgap=%0d required 9 257 32 0",
                     st_first, st_last, st_nen, st_gap_bad);
        end
        checks++;
        if (st_done != 258) begin
            errors++;
            $display("FAIL single_done: cycle=%0d required 258", st_done);
        end
        checks++;
        if (st_stream !== 32'hA5A5_0F0F || st_word !== 32'hA5A5_0F0F) begin
            errors++;
            $display("FAIL single_stream: stream=%h word=%h required a5a50f0f", st_stream, st_word);
        end
        checks++;
        if (st_overlap != 0 || st_ready_busy != 0) begin
            errors++;
            $display("FAIL single_flags: overlap=%0d ready_while_busy=%0d required 0 0", st_overlap, st_ready_busy);
        end
        @(posedge clk); #1;
        checks++;
        if (m_ready !== 1'b1 || m_busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle_after: ready=%b busy=%b required 1 0", m_ready, m_busy);
        end
        $display("test_single: word=%h stream=%h done_cycle=%0d", st_word, st_stream, st_done);
    endtask

    task automatic test_back_to_back();
        sel = 1'b0;
        send_word(32'hFFFF_0000, 1'b1);
        tb_data = 32'h1234_5678;
        capture(300, 8);
        checks++;
        if (st_done != 258 || st_stream !== 32'hFFFF_0000 || st_data_chg != 0) begin
            errors++;
            $display("FAIL b2b_first: done=%0d stream=%h data_changes=%0d required 258 ffff0000 0",
                     st_done, st_stream, st_data_chg);
        end
        @(posedge clk); #1;
        checks++;
        if (m_ready !== 1'b1 || m_load !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: ready=%b load=%b required 1 0", m_ready, m_load);
        end
        @(posedge clk); #1;
        tb_valid = 1'b0;
        checks++;
        if (m_load !== 1'b1 || m_data !== 32'h1234_5678) begin
            errors++;
            $display("FAIL b2b_second_accept: load=%b data=%h required 1 12345678", m_load, m_data);
        end
        capture(300, 8);
        checks++;
        if (st_done != 258 || st_stream !== 32'h1234_5678 || st_nen != 32) begin
            errors++;
            $display("FAIL b2b_second: done=%0d stream=%h n=%0d required 258 12345678 32",
                     st_done, st_stream, st_nen);
        end
        @(posedge clk); #1;
        $display("test_back_to_back: second word=%h done_cycle=%0d", st_word, st_done);
    endtask

    task automatic test_ignore_busy();
        sel = 1'b0;
        send_word(32'h3C3C_C3C3, 1'b0);
        fork
            capture(300, 8);
            begin
                repeat (40) @(posedge clk);
                #2;
                tb_data  = 32'h0BAD_0BAD;
                tb_valid = 1'b1;
                repeat (3) @(posedge clk);
                #2;
                tb_valid = 1'b0;
                tb_data  = 32'h7777_7777;
            end
        join
        checks++;
        if (st_data_chg != 0 || st_ready_busy != 0) begin
            errors++;
            $display("FAIL busy_ignore: data_changes=%0d ready_while_busy=%0d required 0 0",
                     st_data_chg, st_ready_busy);
        end
        checks++;
        if (st_nen != 32 || st_stream !== 32'h3C3C_C3C3 || st_done != 258) begin
            errors++;
            $display("FAIL busy_frame: n=%0d stream=%h done=%0d required 32 3c3cc3c3 258",
                     st_nen, st_stream, st_done);
        end
        @(posedge clk); #1;
        $display("test_ignore_busy: word=%h pulses=%0d", st_word, st_nen);
    endtask

    task automatic test_cpb1();
        sel = 1'b1;
        send_word(32'h8000_0001, 1'b0);
        capture(60, 1);
        checks++;
        if (st_load != 1 || st_first != 2 || st_last != 33 || st_nen != 32 || st_gap_bad != 0) begin
            errors++;
            $display("FAIL cpb1_shift: load=%0d first=%0d last=%0d n=%0d badgap=%0d required 1 2 33 32 0",
                     st_load, st_first, st_last, st_nen, st_gap_bad);
        end
        checks++;
        if (st_done != 34 || st_overlap != 0 || st_stream !== 32'h8000_0001) begin
            errors++;
            $display("FAIL cpb1_done: done=%0d overlap=%0d stream=%h required 34 0 80000001",
                     st_done, st_overlap, st_stream);
        end
        @(posedge clk); #1;
        sel = 1'b0;
        $display("test_cpb1: word=%h done_cycle=%0d", st_word, st_done);
    endtask

    task automatic test_reset_resume();
        int n, k, dones;
        sel = 1'b0;
        send_word(32'h5555_AAAA, 1'b0);
        n = 0; k = 0;
        while (k < 17 && n < 300) begin
            if (m_en) k++;
            if (k < 17) begin
                @(posedge clk); #1;
            end
            n++;
        end
        checks++;
        if (k != 17) begin
            errors++;
            $display("FAIL resume_reach_bit17: pulses=%0d required 17", k);
        end
        n_rst = 1'b0;
        dones = 0;
        #1;
        if (m_done) dones++;
        repeat (2) begin
            @(posedge clk); #1;
            if (m_done) dones++;
        end
        n_rst = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            if (m_done) dones++;
        end
        checks++;
        if (dones != 0 || m_ready !== 1'b1 || m_busy !== 1'b0) begin
            errors++;
            $display("FAIL resume_abort: dones=%0d ready=%b busy=%b required 0 1 0", dones, m_ready, m_busy);
        end
        send_word(32'hDEAD_BEEF, 1'b0);
        capture(300, 8);
        checks++;
        if (st_load != 1 || st_nen != 32 || st_first != 9 || st_done != 258 || st_stream !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL resume_frame: load=%0d n=%0d first=%0d done=%0d stream=%h required 1 32 9 258 deadbeef",
                     st_load, st_nen, st_first, st_done, st_stream);
        end
        @(posedge clk); #1;
        $display("test_reset_resume: word=%h stream=%h", st_word, st_stream);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_ignore_busy();
        test_cpb1();
        test_reset_resume();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
